// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: input conditioning, RUN/HOLD/ADJ sequencing and step/clear/blink pulses for the MM:SS counter.
// Build option: define STOPWATCH_CTRL_SAFE_CLR_EN to ignore clear presses while in RUN.

module stopwatch_ctrl #(
  parameter int DIV_RUN   = 100000000,
  parameter int DIV_ADJ   = 50000000,
  parameter int DIV_BLINK = 25000000,
  parameter int DEB_CNT   = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_pause,
  input  logic btn_clr,
  input  logic sw_adj,
  input  logic sw_sel,
  output logic cnt_en,
  output logic cnt_clr,
  output logic adj_mode,
  output logic adj_sel,
  output logic paused,
  output logic blink
);

  localparam int RW = (DIV_RUN > 1) ? $clog2(DIV_RUN) : 1;
  localparam int AW = (DIV_ADJ > 1) ? $clog2(DIV_ADJ) : 1;
  localparam int BW = (DIV_BLINK > 1) ? $clog2(DIV_BLINK) : 1;
  localparam int DW = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;

  localparam logic [RW-1:0] RUN_LAST   = RW'(DIV_RUN - 1);
  localparam logic [AW-1:0] ADJ_LAST   = AW'(DIV_ADJ - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(DIV_BLINK - 1);
  localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_CNT - 1);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HOLD = 2'd1,
    ST_ADJ  = 2'd2
  } state_t;

  // Synchronizer bit order: {sw_sel, sw_adj, btn_clr, btn_pause}
  logic [3:0]    sync1_r;
  logic [3:0]    sync2_r;
  logic [1:0]    deb_lvl_r;
  logic [1:0]    deb_dly_r;
  logic [1:0]    press_r;
  logic [DW-1:0] deb_cnt_r [2];

  state_t        state_r;
  state_t        state_nxt_s;
  logic          adj_sync_s;
  logic          pause_press_s;
  logic          clr_press_s;
  logic          clr_ok_s;
  logic          adj_entry_s;
  logic          run_tick_s;
  logic          adj_tick_s;

  logic [RW-1:0] run_div_r;
  logic [RW-1:0] run_div_nxt_s;
  logic [AW-1:0] adj_div_r;
  logic [AW-1:0] adj_div_nxt_s;
  logic [BW-1:0] blink_div_r;
  logic [BW-1:0] blink_div_nxt_s;

  logic          cnt_en_r;
  logic          cnt_clr_r;
  logic          adj_mode_r;
  logic          paused_r;
  logic          blink_r;
  logic          cnt_en_nxt_s;
  logic          cnt_clr_nxt_s;
  logic          adj_mode_nxt_s;
  logic          paused_nxt_s;
  logic          blink_nxt_s;

  // Two-flop synchronizers for every raw input.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r <= 4'b0000;
      sync2_r <= 4'b0000;
    end else begin
      sync1_r <= {sw_sel, sw_adj, btn_clr, btn_pause};
      sync2_r <= sync1_r;
    end
  end

  // Button debouncers plus registered one-cycle pulse on each debounced rising edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      deb_lvl_r <= 2'b00;
      deb_dly_r <= 2'b00;
      press_r   <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        deb_cnt_r[i] <= {DW{1'b0}};
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync2_r[i] != deb_lvl_r[i]) begin
          if (deb_cnt_r[i] == DEB_LAST) begin
            deb_lvl_r[i] <= sync2_r[i];
            deb_cnt_r[i] <= {DW{1'b0}};
          end else begin
            deb_cnt_r[i] <= deb_cnt_r[i] + DW'(1);
          end
        end else begin
          deb_cnt_r[i] <= {DW{1'b0}};
        end
      end
      deb_dly_r <= deb_lvl_r;
      press_r   <= deb_lvl_r & ~deb_dly_r;
    end
  end

  assign pause_press_s = press_r[0];
  assign clr_press_s   = press_r[1];
  assign adj_sync_s    = sync2_r[2];
  assign adj_sel       = sync2_r[3];

`ifdef STOPWATCH_CTRL_SAFE_CLR_EN
  assign clr_ok_s = clr_press_s && (state_r != ST_RUN);
`else
  assign clr_ok_s = clr_press_s;
`endif

  // Mode state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode; the adjust switch outranks a pause press.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_RUN: begin
        if (adj_sync_s) begin
          state_nxt_s = ST_ADJ;
        end else if (pause_press_s) begin
          state_nxt_s = ST_HOLD;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_HOLD: begin
        if (adj_sync_s) begin
          state_nxt_s = ST_ADJ;
        end else if (pause_press_s) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_HOLD;
        end
      end
      ST_ADJ: begin
        // Leaving adjust always parks in HOLD so the edited time is not run straight away.
        if (adj_sync_s) begin
          state_nxt_s = ST_ADJ;
        end else begin
          state_nxt_s = ST_HOLD;
        end
      end
      default: begin
        state_nxt_s = ST_RUN;
      end
    endcase
  end

  // Divider, blink and output decode, keyed on the state being entered so outputs line up with it.
  always_comb begin
    adj_entry_s     = (state_nxt_s == ST_ADJ) && (state_r != ST_ADJ);
    run_div_nxt_s   = run_div_r;
    adj_div_nxt_s   = adj_div_r;
    blink_div_nxt_s = blink_div_r;
    blink_nxt_s     = 1'b0;
    run_tick_s      = 1'b0;
    adj_tick_s      = 1'b0;

    if (clr_ok_s || adj_entry_s) begin
      run_div_nxt_s = {RW{1'b0}};
    end else if (state_nxt_s == ST_RUN) begin
      run_tick_s    = (run_div_r == RUN_LAST);
      run_div_nxt_s = run_tick_s ? {RW{1'b0}} : (run_div_r + RW'(1));
    end else begin
      run_div_nxt_s = run_div_r;
    end

    if (adj_entry_s) begin
      adj_div_nxt_s   = {AW{1'b0}};
      blink_div_nxt_s = {BW{1'b0}};
      blink_nxt_s     = 1'b1;
    end else if (state_nxt_s == ST_ADJ) begin
      adj_tick_s    = (adj_div_r == ADJ_LAST);
      adj_div_nxt_s = adj_tick_s ? {AW{1'b0}} : (adj_div_r + AW'(1));
      if (blink_div_r == BLINK_LAST) begin
        blink_div_nxt_s = {BW{1'b0}};
        blink_nxt_s     = ~blink_r;
      end else begin
        blink_div_nxt_s = blink_div_r + BW'(1);
        blink_nxt_s     = blink_r;
      end
    end else begin
      adj_div_nxt_s   = adj_div_r;
      blink_div_nxt_s = blink_div_r;
      blink_nxt_s     = 1'b0;
    end

    cnt_en_nxt_s   = (run_tick_s || adj_tick_s) && !clr_ok_s;
    cnt_clr_nxt_s  = clr_ok_s;
    adj_mode_nxt_s = (state_nxt_s == ST_ADJ);
    paused_nxt_s   = (state_nxt_s == ST_HOLD);
  end

  // Divider and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      run_div_r   <= {RW{1'b0}};
      adj_div_r   <= {AW{1'b0}};
      blink_div_r <= {BW{1'b0}};
      cnt_en_r    <= 1'b0;
      cnt_clr_r   <= 1'b0;
      adj_mode_r  <= 1'b0;
      paused_r    <= 1'b0;
      blink_r     <= 1'b0;
    end else begin
      run_div_r   <= run_div_nxt_s;
      adj_div_r   <= adj_div_nxt_s;
      blink_div_r <= blink_div_nxt_s;
      cnt_en_r    <= cnt_en_nxt_s;
      cnt_clr_r   <= cnt_clr_nxt_s;
      adj_mode_r  <= adj_mode_nxt_s;
      paused_r    <= paused_nxt_s;
      blink_r     <= blink_nxt_s;
    end
  end

  assign cnt_en   = cnt_en_r;
  assign cnt_clr  = cnt_clr_r;
  assign adj_mode = adj_mode_r;
  assign paused   = paused_r;
  assign blink    = blink_r;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl: a history-based reference model queues the expected outputs
// for every clock edge and a negedge monitor pops and compares them against the DUT.

module tb_stopwatch_ctrl;

  localparam int DIV_RUN   = 10;
  localparam int DIV_ADJ   = 4;
  localparam int DIV_BLINK = 3;
  localparam int DEB_CNT   = 4;

  logic clk = 1'b0;
  logic reset;
  logic btn_pause;
  logic btn_clr;
  logic sw_adj;
  logic sw_sel;
  logic cnt_en;
  logic cnt_clr;
  logic adj_mode;
  logic adj_sel;
  logic paused;
  logic blink;

  always #5 clk = ~clk;

  stopwatch_ctrl #(
    .DIV_RUN  (DIV_RUN),
    .DIV_ADJ  (DIV_ADJ),
    .DIV_BLINK(DIV_BLINK),
    .DEB_CNT  (DEB_CNT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_pause(btn_pause),
    .btn_clr  (btn_clr),
    .sw_adj   (sw_adj),
    .sw_sel   (sw_sel),
    .cnt_en   (cnt_en),
    .cnt_clr  (cnt_clr),
    .adj_mode (adj_mode),
    .adj_sel  (adj_sel),
    .paused   (paused),
    .blink    (blink)
  );

  typedef struct packed {
    logic cnt_en;
    logic cnt_clr;
    logic adj_mode;
    logic adj_sel;
    logic paused;
    logic blink;
  } obs_t;

  typedef enum int {M_RUN, M_HOLD, M_ADJ} mstate_t;

  obs_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model state: raw sample histories (bit k = sample k edges ago) and debounced-level histories.
  mstate_t     m_st;
  logic [15:0] h_pause, h_clr, h_adj, h_sel;
  logic [3:0]  d_pause, d_clr;
  int          edge_n, ticks, adj_t0;

  // A button's accepted level flips once the last DEB_CNT samples seen through the 2-flop sync all disagree.
  function automatic logic settled(input logic [15:0] h, input logic cur);
    for (int j = 2; j <= DEB_CNT + 1; j++) begin
      if (h[j] == cur) return 1'b0;
    end
    return 1'b1;
  endfunction

  always @(posedge clk) begin : model
    obs_t    e;
    logic    pause_p, clr_p, honor, entry;
    mstate_t nst;
    e = '0;
    if (reset) begin
      m_st    = M_RUN;
      h_pause = '0; h_clr = '0; h_adj = '0; h_sel = '0;
      d_pause = '0; d_clr = '0;
      edge_n  = 0; ticks = 0; adj_t0 = 0;
    end else begin
      edge_n++;
      h_pause = {h_pause[14:0], btn_pause};
      h_clr   = {h_clr[14:0], btn_clr};
      h_adj   = {h_adj[14:0], sw_adj};
      h_sel   = {h_sel[14:0], sw_sel};
      // Press seen by the mode logic now = debounced level rose two edges back.
      pause_p = d_pause[1] & ~d_pause[2];
      clr_p   = d_clr[1] & ~d_clr[2];
      d_pause = {d_pause[2:0], settled(h_pause, d_pause[0]) ? ~d_pause[0] : d_pause[0]};
      d_clr   = {d_clr[2:0], settled(h_clr, d_clr[0]) ? ~d_clr[0] : d_clr[0]};
      honor   = clr_p;
`ifdef STOPWATCH_CTRL_SAFE_CLR_EN
      honor   = clr_p && (m_st != M_RUN);
`endif
      case (m_st)
        M_RUN:   nst = h_adj[2] ? M_ADJ : (pause_p ? M_HOLD : M_RUN);
        M_HOLD:  nst = h_adj[2] ? M_ADJ : (pause_p ? M_RUN : M_HOLD);
        default: nst = h_adj[2] ? M_ADJ : M_HOLD;
      endcase
      entry = (nst == M_ADJ) && (m_st != M_ADJ);
      if (entry) adj_t0 = edge_n;
      if (honor || entry) ticks = 0;
      else if (nst == M_RUN) ticks++;
      e.cnt_en   = !honor && (((nst == M_RUN) && (ticks > 0) && (ticks % DIV_RUN == 0)) ||
                              ((nst == M_ADJ) && !entry && ((edge_n - adj_t0) % DIV_ADJ == 0)));
      e.cnt_clr  = honor;
      e.adj_mode = (nst == M_ADJ);
      e.paused   = (nst == M_HOLD);
      e.adj_sel  = h_sel[1];
      e.blink    = (nst == M_ADJ) && (((edge_n - adj_t0) / DIV_BLINK) % 2 == 0);
      m_st = nst;
    end
    exp_q.push_back(e);
  end

  task automatic check(input string name, input logic act, input logic req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s at t=%0t: got %0b expected %0b", name, $time, act, req);
    end
  endtask

  always @(negedge clk) begin : monitor
    obs_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("cnt_en",   cnt_en,   e.cnt_en);
      check("cnt_clr",  cnt_clr,  e.cnt_clr);
      check("adj_mode", adj_mode, e.adj_mode);
      check("adj_sel",  adj_sel,  e.adj_sel);
      check("paused",   paused,   e.paused);
      check("blink",    blink,    e.blink);
      check("en_clr_exclusive", cnt_en & cnt_clr, 1'b0);
      check("no_en_in_hold",    cnt_en & paused,  1'b0);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic btn_drive(input logic p, input logic c, input logic v);
    if (p) btn_pause = v;
    if (c) btn_clr = v;
  endtask

  // Bounce for 'bounce' cycles, hold high for 'hold' cycles, bounce again, then release.
  task automatic press(input logic p, input logic c, input int bounce, input int hold);
    for (int i = 0; i < bounce; i++) begin
      @(negedge clk); btn_drive(p, c, 1'($urandom_range(0, 1)));
    end
    @(negedge clk); btn_drive(p, c, 1'b1);
    repeat (hold) @(negedge clk);
    for (int i = 0; i < bounce; i++) begin
      btn_drive(p, c, 1'($urandom_range(0, 1)));
      @(negedge clk);
    end
    btn_drive(p, c, 1'b0);
  endtask

  initial begin : stim
    reset = 1'b1; btn_pause = 1'b0; btn_clr = 1'b0; sw_adj = 1'b0; sw_sel = 1'b0;
    idle(3);
    reset = 1'b0;
    idle(35);                              // free run: pulses every DIV_RUN cycles
    press(1'b1, 1'b0, 2, 12); idle(20);    // bouncy pause press -> HOLD
    press(1'b1, 1'b0, 0, 8);  idle(25);    // clean press -> RUN, phase kept
    sw_sel = 1'b1; sw_adj = 1'b1; idle(25);
    sw_adj = 1'b0; idle(10);               // ADJ -> HOLD
    press(1'b1, 1'b0, 0, 6);  idle(5);
    for (int k = 0; k < 10; k++) begin     // clear at every run-divider phase
      press(1'b0, 1'b1, 0, 6); idle(7 + k);
    end
    press(1'b1, 1'b1, 0, 6); idle(12);     // pause and clear together in RUN
    press(1'b1, 1'b1, 0, 6); idle(12);     // same from HOLD
    sw_adj = 1'b1; press(1'b1, 1'b0, 0, 6); idle(10);
    press(1'b0, 1'b1, 1, 6); idle(10);     // clear while adjusting
    sw_adj = 1'b0; idle(8);
    btn_pause = 1'b1; idle(3);             // reset mid-debounce
    reset = 1'b1; idle(1); reset = 1'b0;
    idle(12); btn_pause = 1'b0; idle(10);
    sw_adj = 1'b1; idle(9);                // reset mid-ADJ
    reset = 1'b1; idle(1); reset = 1'b0; sw_adj = 1'b0;
    idle(15);
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 7))
        0:       idle($urandom_range(1, 15));
        1:       press(1'b1, 1'b0, $urandom_range(0, 3), $urandom_range(1, 10));
        2:       press(1'b0, 1'b1, $urandom_range(0, 3), $urandom_range(1, 10));
        3:       press(1'b1, 1'b1, $urandom_range(0, 2), $urandom_range(3, 8));
        4:       begin sw_adj = ~sw_adj; idle($urandom_range(1, 12)); end
        5:       begin sw_sel = 1'($urandom); idle($urandom_range(1, 4)); end
        6:       if ($urandom_range(0, 9) == 0) begin
                   reset = 1'b1; idle($urandom_range(1, 2)); reset = 1'b0;
                 end else begin
                   idle(DIV_RUN);
                 end
        default: idle($urandom_range(1, 20));
      endcase
    end
    sw_adj = 1'b0;
    idle(30);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d expected entries left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Control/sequencing block for the MM:SS stopwatch counter.
- Conditions raw buttons and switches.
- Owns the run/pause/adjust mode state machine.
- Generates single-cycle enable and clear pulses that step the counter, all in the one `clk` domain. Derived clocks are not used.
- Also drives the adjust-mode blink indicator for the display mux.

Parameters:
- DIV_RUN, 100000000, clk cycles per normal count step (1 Hz at 100 MHz)
- DIV_ADJ, 50000000, clk cycles per adjust step (2 Hz)
- DIV_BLINK, 25000000, clk cycles per blink half-period
- DEB_CNT, 1000000, consecutive stable cycles required to accept a new button level

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high; one clock, and reset is synchronous and active-high
- btn_pause  in  1  raw pause button, asynchronous, bouncy
- btn_clr  in  1  raw clear button, asynchronous, bouncy
- sw_adj  in  1  raw adjust switch (1 = adjust)
- sw_sel  in  1  raw select switch (1 = seconds, 0 = minutes)
- cnt_en  out  1  one-cycle pulse: counter advances one step
- cnt_clr  out  1  one-cycle pulse: counter clears to 00:00
- adj_mode  out  1  level, 1 while in ADJ
- adj_sel  out  1  level, synchronized sw_sel
- paused  out  1  level, 1 while in HOLD
- blink  out  1  blink level for the selected digit pair

Behaviour:
- **Input conditioning**
  - All four raw inputs pass through 2-flop synchronizers.
  - Each button has a debouncer: the debounced level updates only after the synchronized level has differed from it for DEB_CNT consecutive cycles. Any mismatch-free cycle resets the stability count.
  - The press pulse is registered, 1 cycle wide, and fires on the debounced rising edge. Release generates nothing.
  - Total latency is fixed: raw button first sampled high at edge N gives press pulse high after edge N+DEB_CNT+2, and the state/output change is visible after edge N+DEB_CNT+3.
- **Reset** (sampled at clk edge while reset=1)
  - State is RUN.
  - All dividers, debounce counters, sync flops and debounced levels are 0.
  - Outputs: cnt_en=0, cnt_clr=0, adj_mode=0, adj_sel=0, paused=0, blink=0.
  - Reset mid-debounce or mid-division discards partial counts.
- **States**: RUN, HOLD, ADJ. All outputs are registered.
  - RUN: pause_press → HOLD. sync sw_adj=1 → ADJ.
  - HOLD: pause_press → RUN. sync sw_adj=1 → ADJ.
  - ADJ: sync sw_adj=0 → HOLD, always, so the adjusted value is not run immediately. pause_press is ignored.
  - sw_adj=1 has priority over pause_press in the same cycle.
- **Run divider**
  - Counts 0..DIV_RUN-1 only in RUN; cnt_en pulses when it wraps.
  - Pulse period is exactly DIV_RUN cycles. The first pulse after reset release or clear is DIV_RUN cycles later.
  - Holds its value in HOLD, so the phase resumes on return to RUN.
  - Cleared to 0 on entry to ADJ.
- **Adjust divider**
  - Cleared on ADJ entry; counts 0..DIV_ADJ-1 in ADJ; cnt_en pulses on wrap.
  - First adjust pulse occurs DIV_ADJ cycles after entry.
  - An sw_sel change during ADJ does not restart it.
- **Clear**
  - clr_press gives cnt_clr=1 for exactly 1 cycle in any state; state is unchanged.
  - The run divider clears to 0.
  - cnt_en is forced 0 in that same cycle, so a clear never coincides with an increment.
  - pause_press and clr_press in the same cycle both take effect.
- **Outputs**
  - adj_sel follows the synchronized sw_sel (2-cycle latency) in all states.
  - blink: forced 0 outside ADJ. Set to 1 on ADJ entry, then toggles every DIV_BLINK cycles.
  - cnt_en is never high in HOLD.
  - cnt_en and cnt_clr are never simultaneously high.

Optional Feature:
- Macro: STOPWATCH_CTRL_SAFE_CLR_EN.
- **Defined**: clr_press is honoured only in HOLD or ADJ. In RUN it is dropped, with no cnt_clr and no divider clear, to prevent accidental clears while timing.
- **Undefined**: clear is honoured in every state as described above.

Test Plan:
All scenarios use DIV_RUN=10, DIV_ADJ=4, DIV_BLINK=3, DEB_CNT=4.
1. Release reset, no inputs → cnt_en pulses at cycles 10, 20, 30 after release, each 1 cycle wide; paused=0, adj_mode=0, blink=0.
2. Hold btn_pause high from edge N, with a 2-cycle bounce before settling → paused=1 exactly at edge (settle+7); no cnt_en while paused. A second clean press resumes with the divider phase preserved.
3. Set sw_adj=1 in RUN, sw_sel=1 → adj_mode=1, blink=1 on entry toggling every 3 cycles, cnt_en every 4 cycles, adj_sel=1. Drop sw_adj → HOLD, paused=1, blink=0.
4. Press btn_clr in RUN on the cycle a run wrap would occur → cnt_clr=1 for 1 cycle with cnt_en=0, next cnt_en 10 cycles later. With STOPWATCH_CTRL_SAFE_CLR_EN defined: no cnt_clr in RUN, cnt_clr=1 in HOLD.
5. Press pause and clear in the same cycle in RUN → cnt_clr=1 and paused=1. Pulse pause with sw_adj=1 → ADJ with pause ignored.
6. Assert reset mid-debounce and mid-ADJ → all outputs 0 after the edge, state RUN, debounce restarts from 0.
